// File: rtl/sys_reg_mc_pkg.sv
// rtl/sys_reg_mc_pkg.sv - register offsets, CTRL bit positions and channel state for sys_reg_mc
package sys_reg_mc_pkg;

  localparam logic [7:0] ADR_VERSION  = 8'h00;
  localparam logic [7:0] ADR_CTRL     = 8'h04;
  localparam logic [7:0] ADR_LOSS_STS = 8'h08;
  localparam logic [7:0] ADR_IRQ_MASK = 8'h0C;
  localparam logic [7:0] ADR_SCRATCH  = 8'h10;
  localparam logic [7:0] ADR_PERIOD   = 8'h40;

  localparam int CTRL_SOFT_RST  = 0;
  localparam int CTRL_DB_CLK_EN = 8;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_MEAS = 2'd1,
    CH_LOST = 2'd2
  } ch_state_t;

  // Merge new_v into old_v one byte lane at a time
  function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] v;
    for (int b = 0; b < 4; b++) v[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return v;
  endfunction

endpackage

// File: rtl/sys_clk_mon.sv
// rtl/sys_clk_mon.sv - one clock-monitor channel: synchroniser, edge detect, period counter, loss FSM
module sys_clk_mon
  import sys_reg_mc_pkg::*;
#(
  parameter int TMO_W = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_clk_det,
  output logic [31:0] o_period,
  output logic        o_lost
);

  localparam logic [TMO_W-1:0] CNT_MAX = '1;

  logic [2:0]       r_sync;
  ch_state_t        r_state;
  ch_state_t        w_state_nxt;
  logic [TMO_W-1:0] r_cnt;
  logic [TMO_W-1:0] r_period;
  logic             w_rise;

  // [0],[1] form the two-flop synchroniser, [2] holds the previous synced level
  assign w_rise = r_sync[1] & ~r_sync[2];

  // Synchronise the monitored clock and keep one cycle of history
  always_ff @(posedge CLK) begin
    if (RST) r_sync <= '0;
    else     r_sync <= {r_sync[1:0], i_clk_det};
  end

  // Channel state register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= CH_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: first edge starts measuring, a saturated counter means the clock is gone
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CH_IDLE: if (w_rise) w_state_nxt = CH_MEAS;
      CH_MEAS: if (!w_rise && r_cnt == CNT_MAX) w_state_nxt = CH_LOST;
      CH_LOST: if (w_rise) w_state_nxt = CH_MEAS;
      default: w_state_nxt = CH_IDLE;
    endcase
  end

  // Saturating edge-to-edge counter; period is only published for a fully measured interval
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt    <= '0;
      r_period <= '0;
    end else begin
      if (w_rise) begin
        r_cnt <= TMO_W'(1);
        if (r_state == CH_MEAS) r_period <= r_cnt;
      end else if (r_state != CH_IDLE && r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == CH_MEAS && w_state_nxt == CH_LOST) r_period <= '0;
    end
  end

  assign o_period = 32'(r_period);
  assign o_lost   = (r_state == CH_LOST);

endmodule

// File: rtl/sys_reg_mc.sv
// rtl/sys_reg_mc.sv - system register block with clock monitors; SYS_REG_MC_IRQ_EN enables IRQ_MASK/IRQ
module sys_reg_mc
  import sys_reg_mc_pkg::*;
#(
  parameter int          N_CLK   = 8,
  parameter int          RD_LAT  = 3,
  parameter logic [31:0] VERSION = 32'h2021_1006,
  parameter int          TMO_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WREN,
  input  logic [7:0]       WADR,
  input  logic [31:0]      WDAT,
  input  logic [3:0]       WBE,
  input  logic             RDEN,
  input  logic [7:0]       RADR,
  output logic [31:0]      RDAT,
  output logic             RVLD,
  output logic             SOFT_RST,
  output logic             DB_CLK_EN,
  input  logic [N_CLK-1:0] CLK_DET,
  output logic             IRQ
);

  logic             r_wr_en;
  logic [5:0]       r_wr_word;
  logic [31:0]      r_wr_dat;
  logic [3:0]       r_wr_be;
  logic             r_soft_rst;
  logic             r_db_clk_en;
  logic [N_CLK-1:0] r_loss_sts;
  logic [31:0]      r_scratch;
  logic [31:0]      w_period [N_CLK];
  logic [N_CLK-1:0] w_lost;
  logic [7:0]       w_wr_adr;
  logic [7:0]       w_rd_adr;
  logic [31:0]      w_ctrl_cur;
  logic [31:0]      w_ctrl_new;
  logic [31:0]      w_be_dat;
  logic [N_CLK-1:0] w_loss_clr;
  logic [31:0]      w_irq_mask_rd;
  logic [31:0]      w_rd_val;
  logic [RD_LAT-2:0] r_pipe_vld;
  logic [31:0]      r_pipe_dat [RD_LAT-1];
  logic [31:0]      r_rdat;
  logic             r_rvld;
  logic             w_unused;

  genvar g;
  generate
    for (g = 0; g < N_CLK; g++) begin : g_mon
      sys_clk_mon #(.TMO_W(TMO_W)) u_mon (
        .CLK      (CLK),
        .RST      (RST),
        .i_clk_det(CLK_DET[g]),
        .o_period (w_period[g]),
        .o_lost   (w_lost[g])
      );
    end
  endgenerate

  assign w_wr_adr   = {r_wr_word, 2'b00};
  assign w_rd_adr   = {RADR[7:2], 2'b00};
  assign w_ctrl_new = apply_be(w_ctrl_cur, r_wr_dat, r_wr_be);
  assign w_be_dat   = apply_be(32'h0, r_wr_dat, r_wr_be);
  assign w_loss_clr = (r_wr_en && w_wr_adr == ADR_LOSS_STS) ? w_be_dat[N_CLK-1:0] : '0;

  // Current CTRL word assembled from its two implemented bits
  always_comb begin
    w_ctrl_cur = '0;
    w_ctrl_cur[CTRL_SOFT_RST]  = r_soft_rst;
    w_ctrl_cur[CTRL_DB_CLK_EN] = r_db_clk_en;
  end

  // Write stage: one register slice in front of the register file
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_en   <= 1'b0;
      r_wr_word <= '0;
      r_wr_dat  <= '0;
      r_wr_be   <= '0;
    end else begin
      r_wr_en   <= WREN;
      r_wr_word <= WADR[7:2];
      r_wr_dat  <= WDAT;
      r_wr_be   <= WBE;
    end
  end

  // Register file; loss status set wins over a same-cycle clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_soft_rst  <= 1'b0;
      r_db_clk_en <= 1'b0;
      r_scratch   <= '0;
      r_loss_sts  <= '0;
    end else begin
      if (r_wr_en && w_wr_adr == ADR_CTRL) begin
        r_soft_rst  <= w_ctrl_new[CTRL_SOFT_RST];
        r_db_clk_en <= w_ctrl_new[CTRL_DB_CLK_EN];
      end
      if (r_wr_en && w_wr_adr == ADR_SCRATCH) r_scratch <= apply_be(r_scratch, r_wr_dat, r_wr_be);
      r_loss_sts <= (r_loss_sts & ~w_loss_clr) | w_lost;
    end
  end

`ifdef SYS_REG_MC_IRQ_EN
  logic [N_CLK-1:0] r_irq_mask;
  logic             r_irq;
  logic [31:0]      w_mask_new;
  logic             w_unused_mask;

  assign w_mask_new    = apply_be(32'(r_irq_mask), r_wr_dat, r_wr_be);
  assign w_unused_mask = ^w_mask_new;

  // Interrupt mask, all channels masked out of reset
  always_ff @(posedge CLK) begin
    if (RST)                                   r_irq_mask <= '1;
    else if (r_wr_en && w_wr_adr == ADR_IRQ_MASK) r_irq_mask <= w_mask_new[N_CLK-1:0];
  end

  // Registered interrupt from unmasked loss status
  always_ff @(posedge CLK) begin
    if (RST) r_irq <= 1'b0;
    else     r_irq <= |(r_loss_sts & ~r_irq_mask);
  end

  assign IRQ           = r_irq;
  assign w_irq_mask_rd = 32'(r_irq_mask);
`else
  assign IRQ           = 1'b0;
  assign w_irq_mask_rd = '0;
`endif

  // Read address decode on the RDEN cycle; unmapped addresses read 0
  always_comb begin
    w_rd_val = '0;
    case (w_rd_adr)
      ADR_VERSION:  w_rd_val = VERSION;
      ADR_CTRL:     w_rd_val = w_ctrl_cur;
      ADR_LOSS_STS: w_rd_val = 32'(r_loss_sts);
      ADR_IRQ_MASK: w_rd_val = w_irq_mask_rd;
      ADR_SCRATCH:  w_rd_val = r_scratch;
      default: begin
        for (int i = 0; i < N_CLK; i++)
          if (w_rd_adr == ADR_PERIOD + 8'(4 * i)) w_rd_val = w_period[i];
      end
    endcase
  end

  // Read pipeline: RD_LAT-1 internal stages then the RDAT/RVLD output stage
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < RD_LAT - 1; i++) r_pipe_dat[i] <= '0;
      r_rvld <= 1'b0;
      r_rdat <= '0;
    end else begin
      r_pipe_vld[0] <= RDEN;
      r_pipe_dat[0] <= w_rd_val;
      for (int i = 1; i < RD_LAT - 1; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_dat[i] <= r_pipe_dat[i-1];
      end
      r_rvld <= r_pipe_vld[RD_LAT-2];
      if (r_pipe_vld[RD_LAT-2]) r_rdat <= r_pipe_dat[RD_LAT-2];
    end
  end

  assign RDAT      = r_rdat;
  assign RVLD      = r_rvld;
  assign SOFT_RST  = r_soft_rst;
  assign DB_CLK_EN = r_db_clk_en;
  assign w_unused  = ^{WADR[1:0], RADR[1:0], w_ctrl_new, w_be_dat};

endmodule

// File: tb/tb_sys_reg_mc.sv
// tb/tb_sys_reg_mc.sv - directed self-checking bench for sys_reg_mc
module tb_sys_reg_mc;

  localparam int          N_CLK   = 8;
  localparam int          RD_LAT  = 3;
  localparam int          TMO_W   = 8;
  localparam logic [31:0] VERSION = 32'h2021_1006;
`ifdef SYS_REG_MC_IRQ_EN
  localparam logic [31:0] MASK_RST = 32'h0000_00FF;
  localparam logic [31:0] MASK_F   = 32'h0000_000F;
  localparam logic        IRQ_ON   = 1'b1;
`else
  localparam logic [31:0] MASK_RST = 32'h0;
  localparam logic [31:0] MASK_F   = 32'h0;
  localparam logic        IRQ_ON   = 1'b0;
`endif

  logic             CLK, RST, WREN, RDEN, RVLD, SOFT_RST, DB_CLK_EN, IRQ;
  logic [7:0]       WADR, RADR;
  logic [31:0]      WDAT, RDAT;
  logic [3:0]       WBE;
  logic [N_CLK-1:0] CLK_DET;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_edge = 0;
  logic        run0 = 1'b0;
  logic        run2 = 1'b0;
  logic [31:0] cap_data[$];
  int          cap_cyc[$];

  sys_reg_mc #(.N_CLK(N_CLK), .RD_LAT(RD_LAT), .VERSION(VERSION), .TMO_W(TMO_W)) dut (
    .CLK(CLK), .RST(RST), .WREN(WREN), .WADR(WADR), .WDAT(WDAT), .WBE(WBE),
    .RDEN(RDEN), .RADR(RADR), .RDAT(RDAT), .RVLD(RVLD), .SOFT_RST(SOFT_RST),
    .DB_CLK_EN(DB_CLK_EN), .CLK_DET(CLK_DET), .IRQ(IRQ)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    n_edge++;
  end

  // RVLD monitor on the falling edge, tagged with the rising-edge count
  initial forever begin
    @(negedge CLK);
    if (RVLD === 1'b1) begin
      cap_data.push_back(RDAT);
      cap_cyc.push_back(n_edge);
    end
  end

  // Monitored clocks: 20-CLK period while enabled
  initial begin
    CLK_DET = '0;
    forever begin
      repeat (10) @(posedge CLK);
      #1;
      if (run0) CLK_DET[0] = ~CLK_DET[0];
      if (run2) CLK_DET[2] = ~CLK_DET[2];
    end
  end

  task automatic do_write(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] be);
    @(posedge CLK); #1;
    WREN = 1'b1; WADR = adr; WDAT = dat; WBE = be;
    @(posedge CLK); #1;
    WREN = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic do_read(input logic [7:0] adr, output logic [31:0] data, output int lat, output int cnt);
    int issue;
    cap_data.delete(); cap_cyc.delete();
    @(posedge CLK); #1;
    issue = n_edge; RDEN = 1'b1; RADR = adr;
    @(posedge CLK); #1;
    RDEN = 1'b0;
    repeat (RD_LAT + 3) @(posedge CLK);
    #1;
    cnt = cap_data.size();
    if (cnt > 0) begin data = cap_data[0]; lat = cap_cyc[0] - issue; end
    else begin data = '0; lat = -1; end
  endtask

  task automatic test_reset;
    logic [31:0] d; int lat, cnt;
    if (RVLD !== 1'b0) begin n_fail++; $display("FAIL rst_rvld: got %b want 0", RVLD); end n_cmp++;
    if (SOFT_RST !== 1'b0) begin n_fail++; $display("FAIL rst_soft: got %b want 0", SOFT_RST); end n_cmp++;
    if (DB_CLK_EN !== 1'b0) begin n_fail++; $display("FAIL rst_db: got %b want 0", DB_CLK_EN); end n_cmp++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", IRQ); end n_cmp++;
    do_read(8'h00, d, lat, cnt);
    if (lat !== RD_LAT) begin n_fail++; $display("FAIL ver_lat: got %0d want %0d", lat, RD_LAT); end n_cmp++;
    if (d !== 32'h2021_1006) begin n_fail++; $display("FAIL ver_dat: got %h want 20211006", d); end n_cmp++;
    if (cnt !== 1) begin n_fail++; $display("FAIL ver_cnt: got %0d want 1", cnt); end n_cmp++;
    do_read(8'h04, d, lat, cnt);
    if (d !== 32'h0) begin n_fail++; $display("FAIL rst_ctrl: got %h want 0", d); end n_cmp++;
    do_read(8'h0C, d, lat, cnt);
    if (d !== MASK_RST) begin n_fail++; $display("FAIL rst_mask: got %h want %h", d, MASK_RST); end n_cmp++;
    do_read(8'h10, d, lat, cnt);
    if (d !== 32'h0) begin n_fail++; $display("FAIL rst_scratch: got %h want 0", d); end n_cmp++;
    do_read(8'h48, d, lat, cnt);
    if (d !== 32'h0) begin n_fail++; $display("FAIL rst_period2: got %h want 0", d); end n_cmp++;
  endtask

  task automatic test_scratch_be;
    logic [31:0] d; int lat, cnt;
    do_write(8'h10, 32'hA5A5_5A5A, 4'b0011);
    do_read(8'h10, d, lat, cnt);
    if (d !== 32'h0000_5A5A) begin n_fail++; $display("FAIL scr_be_lo: got %h want 00005a5a", d); end n_cmp++;
    do_write(8'h13, 32'h1234_5678, 4'b1100);
    do_read(8'h10, d, lat, cnt);
    if (d !== 32'h1234_5A5A) begin n_fail++; $display("FAIL scr_be_hi: got %h want 12345a5a", d); end n_cmp++;
  endtask

  task automatic test_ctrl;
    logic [31:0] d; int lat, cnt;
    do_write(8'h04, 32'hFFFF_FFFF, 4'hF);
    do_read(8'h04, d, lat, cnt);
    if (d !== 32'h0000_0101) begin n_fail++; $display("FAIL ctrl_rd: got %h want 00000101", d); end n_cmp++;
    if (SOFT_RST !== 1'b1) begin n_fail++; $display("FAIL ctrl_soft1: got %b want 1", SOFT_RST); end n_cmp++;
    if (DB_CLK_EN !== 1'b1) begin n_fail++; $display("FAIL ctrl_db1: got %b want 1", DB_CLK_EN); end n_cmp++;
    do_write(8'h04, 32'h0, 4'b0001);
    do_read(8'h04, d, lat, cnt);
    if (d !== 32'h0000_0100) begin n_fail++; $display("FAIL ctrl_be: got %h want 00000100", d); end n_cmp++;
    if (SOFT_RST !== 1'b0) begin n_fail++; $display("FAIL ctrl_soft0: got %b want 0", SOFT_RST); end n_cmp++;
  endtask

  task automatic test_ro_unmapped;
    logic [31:0] d; int lat, cnt;
    do_write(8'h00, 32'hDEAD_BEEF, 4'hF);
    do_read(8'h00, d, lat, cnt);
    if (d !== 32'h2021_1006) begin n_fail++; $display("FAIL ro_ver: got %h want 20211006", d); end n_cmp++;
    do_write(8'h20, 32'hDEAD_BEEF, 4'hF);
    do_read(8'h20, d, lat, cnt);
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmap_20: got %h want 0", d); end n_cmp++;
    do_read(8'h60, d, lat, cnt);
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmap_p8: got %h want 0", d); end n_cmp++;
    if (cnt !== 1) begin n_fail++; $display("FAIL unmap_cnt: got %0d want 1", cnt); end n_cmp++;
    do_write(8'h44, 32'hDEAD_BEEF, 4'hF);
    do_read(8'h44, d, lat, cnt);
    if (d !== 32'h0) begin n_fail++; $display("FAIL ro_period1: got %h want 0", d); end n_cmp++;
  endtask

  task automatic test_rw_same;
    int issue;
    cap_data.delete(); cap_cyc.delete();
    @(posedge CLK); #1;
    issue = n_edge;
    WREN = 1'b1; WADR = 8'h10; WDAT = 32'hCAFE_F00D; WBE = 4'hF;
    RDEN = 1'b1; RADR = 8'h10;
    @(posedge CLK); #1;
    WREN = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RDEN = 1'b0;
    repeat (RD_LAT + 3) @(posedge CLK);
    #1;
    if (cap_data.size() !== 3) begin n_fail++; $display("FAIL rw_cnt: got %0d want 3", cap_data.size()); end
    else begin
      if (cap_data[0] !== 32'h1234_5A5A) begin n_fail++; $display("FAIL rw_same: got %h want 12345a5a", cap_data[0]); end
      if (cap_data[1] !== 32'h1234_5A5A) begin n_fail++; $display("FAIL rw_next: got %h want 12345a5a", cap_data[1]); end
      if (cap_data[2] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rw_new: got %h want cafef00d", cap_data[2]); end
      if (cap_cyc[0] - issue !== RD_LAT) begin n_fail++; $display("FAIL rw_lat: got %0d want %0d", cap_cyc[0] - issue, RD_LAT); end
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back;
    int issue;
    logic [7:0]  adr [4];
    logic [31:0] exp [4];
    do_write(8'h0C, 32'h0000_000F, 4'hF);
    adr[0] = 8'h04; exp[0] = 32'h0000_0100;
    adr[1] = 8'h08; exp[1] = 32'h0;
    adr[2] = 8'h0C; exp[2] = MASK_F;
    adr[3] = 8'h10; exp[3] = 32'hCAFE_F00D;
    cap_data.delete(); cap_cyc.delete();
    @(posedge CLK); #1;
    issue = n_edge;
    for (int k = 0; k < 4; k++) begin
      RDEN = 1'b1; RADR = adr[k];
      @(posedge CLK); #1;
    end
    RDEN = 1'b0;
    repeat (RD_LAT + 3) @(posedge CLK);
    #1;
    if (cap_data.size() !== 4) begin n_fail++; $display("FAIL b2b_cnt: got %0d want 4", cap_data.size()); end
    n_cmp++;
    for (int k = 0; k < 4 && k < cap_data.size(); k++) begin
      if (cap_data[k] !== exp[k]) begin n_fail++; $display("FAIL b2b_dat%0d: got %h want %h", k, cap_data[k], exp[k]); end
      n_cmp++;
      if (cap_cyc[k] - issue !== RD_LAT + k) begin n_fail++; $display("FAIL b2b_cyc%0d: got %0d want %0d", k, cap_cyc[k] - issue, RD_LAT + k); end
      n_cmp++;
    end
  endtask

  task automatic test_period;
    logic [31:0] d; int lat, cnt;
    run0 = 1'b1; run2 = 1'b1;
    repeat (80) @(posedge CLK);
    do_read(8'h48, d, lat, cnt);
    if (d !== 32'd20) begin n_fail++; $display("FAIL period2: got %0d want 20", d); end n_cmp++;
    do_read(8'h40, d, lat, cnt);
    if (d !== 32'd20) begin n_fail++; $display("FAIL period0: got %0d want 20", d); end n_cmp++;
    do_read(8'h08, d, lat, cnt);
    if (d !== 32'h0) begin n_fail++; $display("FAIL sts_run: got %h want 0", d); end n_cmp++;
  endtask

  task automatic test_loss;
    logic [31:0] d; int lat, cnt;
    run0 = 1'b0;
    repeat (150) @(posedge CLK);
    do_read(8'h08, d, lat, cnt);
    if (d !== 32'h0) begin n_fail++; $display("FAIL sts_early: got %h want 0", d); end n_cmp++;
    repeat (150) @(posedge CLK);
    do_read(8'h08, d, lat, cnt);
    if (d !== 32'h1) begin n_fail++; $display("FAIL sts_lost: got %h want 1", d); end n_cmp++;
    do_read(8'h40, d, lat, cnt);
    if (d !== 32'h0) begin n_fail++; $display("FAIL period0_lost: got %h want 0", d); end n_cmp++;
    do_read(8'h48, d, lat, cnt);
    if (d !== 32'd20) begin n_fail++; $display("FAIL period2_live: got %0d want 20", d); end n_cmp++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b want 0", IRQ); end n_cmp++;
    do_write(8'h0C, 32'h0, 4'hF);
    repeat (2) @(posedge CLK);
    #1;
    if (IRQ !== IRQ_ON) begin n_fail++; $display("FAIL irq_unmasked: got %b want %b", IRQ, IRQ_ON); end n_cmp++;
    do_write(8'h08, 32'h1, 4'hF);
    do_read(8'h08, d, lat, cnt);
    if (d !== 32'h1) begin n_fail++; $display("FAIL sts_clr_lost: got %h want 1", d); end n_cmp++;
    run0 = 1'b1;
    repeat (40) @(posedge CLK);
    do_read(8'h08, d, lat, cnt);
    if (d !== 32'h1) begin n_fail++; $display("FAIL sts_sticky: got %h want 1", d); end n_cmp++;
    do_write(8'h08, 32'h1, 4'hF);
    do_read(8'h08, d, lat, cnt);
    if (d !== 32'h0) begin n_fail++; $display("FAIL sts_w1c: got %h want 0", d); end n_cmp++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_clr: got %b want 0", IRQ); end n_cmp++;
  endtask

  task automatic test_reset_inflight;
    logic [31:0] d; int lat, cnt;
    do_write(8'h04, 32'h1, 4'hF);
    if (SOFT_RST !== 1'b1) begin n_fail++; $display("FAIL pre_rst_soft: got %b want 1", SOFT_RST); end n_cmp++;
    cap_data.delete(); cap_cyc.delete();
    @(posedge CLK); #1;
    RDEN = 1'b1; RADR = 8'h00;
    @(posedge CLK); #1;
    RDEN = 1'b0; RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (RD_LAT + 3) @(posedge CLK);
    #1;
    if (cap_data.size() !== 0) begin n_fail++; $display("FAIL rst_drop: got %0d pulses want 0", cap_data.size()); end n_cmp++;
    if (SOFT_RST !== 1'b0) begin n_fail++; $display("FAIL rst2_soft: got %b want 0", SOFT_RST); end n_cmp++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL rst2_irq: got %b want 0", IRQ); end n_cmp++;
    do_read(8'h0C, d, lat, cnt);
    if (d !== MASK_RST) begin n_fail++; $display("FAIL rst2_mask: got %h want %h", d, MASK_RST); end n_cmp++;
  endtask

  initial begin
    RST = 1'b1; WREN = 1'b0; WADR = '0; WDAT = '0; WBE = '0; RDEN = 1'b0; RADR = '0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    test_reset();
    test_scratch_be();
    test_ctrl();
    test_ro_unmapped();
    test_rw_same();
    test_back_to_back();
    test_period();
    test_loss();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
